// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pe_pkg
//  Description : Shared defaults and width helpers for the request
//                debounce/latch front end of the priority encoder path.
//  Contents    : WIDTH_DEF, DEBOUNCE_DEF, clog2_min1() width helper
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int DEBOUNCE_DEF = 4;

  // $clog2 clamped to at least 1 bit, so a 1-channel build or a
  // single-cycle debounce still gets a legal vector width.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bit
//  Description : One request channel: 2-flop synchroniser, persistence
//                counter and accepted-level flop, plus rise indications.
//  Ports       : clk, rst      - clock, async active-high reset
//                ena           - 0 freezes counter/stable, sync keeps running
//                raw           - raw asynchronous input
//                stable        - debounced level
//                rise          - registered 1-cycle strobe on 0->1 acceptance
//                rise_set      - combinational: a 0->1 acceptance happens at
//                                the coming edge (lets the parent capture on
//                                the same edge that raises stable)
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
  import pe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic rise_set
);

  localparam int               CNT_W   = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_rise;
  logic             w_differ;
  logic             w_expire;

  // Synchroniser runs regardless of ena so the level is settled on re-enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_differ = (r_sync2 != r_stable);
  assign w_expire = ena && w_differ && (r_cnt == CNT_MAX);
  assign rise_set = w_expire && r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_rise <= rise_set;
      if (ena) begin
        if (!w_differ) begin
          // Level returned to the accepted value: any partial count is void.
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign stable = r_stable;
  assign rise   = r_rise;

endmodule
`default_nettype wire

// File: rtl/req_debounce_latch.sv
`default_nettype none
// ============================================================================
//  Module      : req_debounce_latch
//  Description : Synchronises and debounces WIDTH request lines, captures
//                each debounced rising edge into a sticky pending vector that
//                the priority encoder consumes and acknowledges by index.
//  Ports       : clk, rst            - clock, async active-high reset
//                ena                 - debounce enable (acks always honoured)
//                raw_in[WIDTH]       - raw asynchronous requests
//                ack_valid, ack_idx  - consumer acknowledge of one index
//                stable_out[WIDTH]   - debounced levels
//                rise_pulse[WIDTH]   - 1-cycle strobe per debounced rise
//                pending[WIDTH]      - sticky captured requests
//                overrun[WIDTH]      - rise arrived while already pending
//                any_pending         - registered OR of pending
//  Revision    : 1.0 - initial release
// ============================================================================
module req_debounce_latch
  import pe_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int IDX_W           = clog2_min1(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             ack_valid,
  input  logic [IDX_W-1:0] ack_idx,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] overrun,
  output logic             any_pending
);

  logic [WIDTH-1:0] w_rise_set;
  logic [WIDTH-1:0] w_ack_hit;
  logic [WIDTH-1:0] w_pending_nxt;
  logic [WIDTH-1:0] w_overrun_nxt;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_overrun;
  logic             r_any_pending;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce_bit (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .raw      (raw_in[i]),
        .stable   (stable_out[i]),
        .rise     (rise_pulse[i]),
        .rise_set (w_rise_set[i])
      );

      // Indices >= WIDTH match no channel and are therefore ignored.
      assign w_ack_hit[i] = ack_valid && (ack_idx == IDX_W'(i));
    end
  endgenerate

  // A rise beats a same-cycle ack; overrun needs a rise onto an
  // already-pending bit that is not being served this cycle.
  assign w_pending_nxt = w_rise_set | (r_pending & ~w_ack_hit);
  assign w_overrun_nxt = (w_rise_set & r_pending & ~w_ack_hit)
                       | (r_overrun & ~w_ack_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending     <= '0;
      r_overrun     <= '0;
      r_any_pending <= 1'b0;
    end else begin
      r_pending     <= w_pending_nxt;
      r_overrun     <= w_overrun_nxt;
      r_any_pending <= |w_pending_nxt;
    end
  end

  assign pending     = r_pending;
  assign overrun     = r_overrun;
  assign any_pending = r_any_pending;

endmodule
`default_nettype wire

// File: tb/tb_req_debounce_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_debounce_latch
//  Description : Self-checking bench for req_debounce_latch: directed steps
//                followed by a randomized phase, all outputs compared each
//                cycle against a behavioural model of the channel rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_debounce_latch;

  localparam int W   = 8;
  localparam int DEB = 4;
  localparam int IW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic [W-1:0]  raw_in;
  logic          ack_valid;
  logic [IW-1:0] ack_idx;
  logic [W-1:0]  stable_out;
  logic [W-1:0]  rise_pulse;
  logic [W-1:0]  pending;
  logic [W-1:0]  overrun;
  logic          any_pending;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [W-1:0] m_s1, m_s2, m_stable, m_rise, m_pend, m_ovr;
  logic         m_any;
  int           m_run [W];   // consecutive enabled cycles the synced level disagreed

  always #5 clk = ~clk;

  req_debounce_latch #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DEB),
    .IDX_W           (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .raw_in      (raw_in),
    .ack_valid   (ack_valid),
    .ack_idx     (ack_idx),
    .stable_out  (stable_out),
    .rise_pulse  (rise_pulse),
    .pending     (pending),
    .overrun     (overrun),
    .any_pending (any_pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0;
    m_pend = '0; m_ovr = '0; m_any = 1'b0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  // Apply one clock edge of the channel rules to the model.
  task automatic model_edge();
    logic [W-1:0] rs;
    logic         ack;
    if (rst) begin
      model_reset();
      return;
    end
    rs = '0;
    for (int i = 0; i < W; i++) begin
      if (ena) begin
        if (m_s2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_stable[i] = m_s2[i];
            m_run[i]    = 0;
            rs[i]       = m_s2[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    for (int i = 0; i < W; i++) begin
      ack = ack_valid && (int'(ack_idx) == i);
      if (rs[i]) begin
        if (m_pend[i] && !ack) m_ovr[i] = 1'b1;
        if (ack) m_ovr[i] = 1'b0;
        m_pend[i] = 1'b1;
      end else if (ack) begin
        m_pend[i] = 1'b0;
        m_ovr[i]  = 1'b0;
      end
    end
    m_rise = rs;
    m_any  = |m_pend;
    m_s2   = m_s1;
    m_s1   = raw_in;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".stable"},  32'(stable_out),  32'(m_stable));
    chk({ph, ".rise"},    32'(rise_pulse),  32'(m_rise));
    chk({ph, ".pending"}, 32'(pending),     32'(m_pend));
    chk({ph, ".overrun"}, 32'(overrun),     32'(m_ovr));
    chk({ph, ".any"},     32'(any_pending), 32'(m_any));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear without an edge.
  task automatic async_reset(input string ph);
    #4;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(ph);
    chk({ph, ".pend0"}, 32'(pending), 32'h0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ena = 1'b1; raw_in = '0; ack_valid = 1'b0; ack_idx = '0;
    model_reset();
    repeat (3) step("reset");

    // Latency from reset release with all lines high
    rst = 1'b0;
    raw_in = 8'hFF;
    for (int e = 1; e <= 6; e++) begin
      step("ff_lat");
      chk("ff_lat.pending", 32'(pending), (e < 6) ? 32'h0 : 32'hFF);
    end
    chk("ff_lat.rise", 32'(rise_pulse), 32'hFF);
    repeat (2) step("ff_hold");

    async_reset("arst1");
    for (int e = 1; e <= 6; e++) begin
      step("ff_lat2");
      chk("ff_lat2.pending", 32'(pending), (e < 6) ? 32'h0 : 32'hFF);
    end
    raw_in = 8'h00;
    async_reset("arst2");
    repeat (4) step("settle");

    // Single request
    raw_in = 8'h04;
    for (int e = 1; e <= 6; e++) step("single");
    chk("single.stable",  32'(stable_out),  32'h04);
    chk("single.pending", 32'(pending),     32'h04);
    chk("single.rise",    32'(rise_pulse),  32'h04);
    chk("single.any",     32'(any_pending), 32'h1);
    step("single_after");
    chk("single.rise_off", 32'(rise_pulse), 32'h0);

    // Glitch on bit 5 shorter than the debounce window
    raw_in = 8'h24;
    repeat (3) step("glitch_on");
    raw_in = 8'h04;
    for (int k = 0; k < 20; k++) begin
      step("glitch");
      chk("glitch.stable", 32'(stable_out), 32'h04);
      chk("glitch.rise",   32'(rise_pulse), 32'h0);
    end

    // Ack clears
    ack_valid = 1'b1; ack_idx = 3'd2;
    step("ack2");
    ack_valid = 1'b0;
    chk("ack2.pending", 32'(pending), 32'h0);

    // Rise and ack of the same bit on the same edge (pending clear, then set)
    for (int r = 0; r < 2; r++) begin
      raw_in = 8'h00;
      repeat (8) step("coll_low");
      raw_in = 8'h04;
      repeat (5) step("coll_high");
      ack_valid = 1'b1; ack_idx = 3'd2;
      step("coll");
      ack_valid = 1'b0;
      chk("coll.pending", 32'(pending), 32'h04);
      chk("coll.overrun", 32'(overrun), 32'h0);
    end

    // Overrun on bit 1
    raw_in = 8'h06;
    repeat (8) step("ovr_a");
    raw_in = 8'h04;
    repeat (8) step("ovr_b");
    raw_in = 8'h06;
    repeat (6) step("ovr_c");
    chk("ovr.overrun", 32'(overrun), 32'h02);
    chk("ovr.pending", 32'(pending), 32'h06);
    ack_valid = 1'b1; ack_idx = 3'd1;
    step("ovr_ack");
    ack_valid = 1'b0;
    chk("ovr_ack.pending", 32'(pending), 32'h04);
    chk("ovr_ack.overrun", 32'(overrun), 32'h0);

    // Enable gating
    raw_in = 8'h00;
    repeat (8) step("ena_prep");
    ena = 1'b0;
    raw_in = 8'hFF;
    for (int k = 0; k < 40; k++) begin
      ack_valid = (k == 20);
      ack_idx   = 3'd2;
      step("ena_off");
      chk("ena_off.rise",   32'(rise_pulse), 32'h0);
      chk("ena_off.stable", 32'(stable_out), 32'h0);
    end
    ack_valid = 1'b0;
    chk("ena_off.ack", 32'(pending), 32'h0);
    ena = 1'b1;
    for (int e = 1; e <= DEB; e++) begin
      step("ena_on");
      chk("ena_on.pending", 32'(pending), (e < DEB) ? 32'h0 : 32'hFF);
    end

    // Randomized phase: slowly toggling lines, occasional disable and acks
    for (int k = 0; k < 1500; k++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 7) == 0) raw_in[b] = ~raw_in[b];
      ena       = ($urandom_range(0, 9) != 0);
      ack_valid = ($urandom_range(0, 3) == 0);
      ack_idx   = IW'($urandom_range(0, 7));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
